// File: rtl/muldiv_ctrl.sv
// Sequencer for the multi-cycle multiply/divide units.
// Owns HI/LO, MTHI/MTLO writes and div-by-zero detection.
module muldiv_ctrl #(
    parameter int MULT_LAT = 33,
    parameter int DIV_LAT  = 34,
    parameter int CNT_W    = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        op_req,
    input  logic        op_sel,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        hilo_we,
    input  logic        hilo_sel,
    input  logic [31:0] hilo_wdata,
    output logic        op_ack,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        mult_start,
    output logic        div_start,
    output logic [31:0] mult_a,
    output logic [31:0] mult_b,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    output logic        mult_rst,
    output logic        div_rst,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo
);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        CAPTURE,
        FINISH
    } state_t;

    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT - 2);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT - 2);

    state_t           state;
    state_t           state_nx;
    logic             accept;
    logic             zero_div;
    logic             sel_q;
    logic [CNT_W-1:0] cnt;

    assign zero_div = op_sel && (op_b == 32'd0);

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        unique case (state)
            IDLE: begin
                if (op_req) begin
                    accept   = 1'b1;
                    state_nx = zero_div ? FINISH : LAUNCH;
                end
            end
            LAUNCH:  state_nx = WAIT;
            WAIT:    if (cnt == '0) state_nx = CAPTURE;
            CAPTURE: state_nx = FINISH;
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // FINISH with div_zero set can only follow a div-by-zero acceptance
    assign op_ack     = (state == LAUNCH) || (state == FINISH && div_zero);
    assign busy       = (state != IDLE);
    assign done       = (state == FINISH);
    assign mult_start = (state == LAUNCH) && !sel_q;
    assign div_start  = (state == LAUNCH) && sel_q;
    assign mult_rst   = ~reset;
    assign div_rst    = ~reset;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            sel_q    <= 1'b0;
            div_zero <= 1'b0;
            cnt      <= '0;
            hi       <= 32'd0;
            lo       <= 32'd0;
            mult_a   <= 32'd0;
            mult_b   <= 32'd0;
            div_a    <= 32'd0;
            div_b    <= 32'd0;
        end else begin
            state <= state_nx;
            if (state == IDLE && hilo_we) begin
                if (hilo_sel) hi <= hilo_wdata;
                else          lo <= hilo_wdata;
            end
            if (accept) begin
                sel_q    <= op_sel;
                div_zero <= zero_div;
                if (op_sel) begin
                    div_a <= op_a;
                    div_b <= op_b;
                end else begin
                    mult_a <= op_a;
                    mult_b <= op_b;
                end
            end
            if (state == LAUNCH)
                cnt <= sel_q ? DIV_CNT : MULT_CNT;
            else if (state == WAIT && cnt != '0)
                cnt <= cnt - 1'b1;
            if (state == CAPTURE) begin
                hi <= sel_q ? div_hi : mult_hi;
                lo <= sel_q ? div_lo : mult_lo;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized bench for muldiv_ctrl against a
// transaction-level timeline model with behavioural units.
module tb_muldiv_ctrl;

    localparam int MLAT = 33;
    localparam int DLAT = 34;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        op_req = 1'b0;
    logic        op_sel = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        hilo_we = 1'b0;
    logic        hilo_sel = 1'b0;
    logic [31:0] hilo_wdata = '0;
    logic [31:0] mult_hi = '0;
    logic [31:0] mult_lo = '0;
    logic [31:0] div_hi = '0;
    logic [31:0] div_lo = '0;
    logic        op_ack, busy, done, div_zero;
    logic [31:0] hi, lo;
    logic        mult_start, div_start;
    logic [31:0] mult_a, mult_b, div_a, div_b;
    logic        mult_rst, div_rst;

    muldiv_ctrl #(.MULT_LAT(MLAT), .DIV_LAT(DLAT), .CNT_W(6)) dut (
        .clock(clock), .reset(reset),
        .op_req(op_req), .op_sel(op_sel),
        .op_a(op_a), .op_b(op_b),
        .hilo_we(hilo_we), .hilo_sel(hilo_sel),
        .hilo_wdata(hilo_wdata),
        .op_ack(op_ack), .busy(busy), .done(done),
        .div_zero(div_zero), .hi(hi), .lo(lo),
        .mult_start(mult_start), .div_start(div_start),
        .mult_a(mult_a), .mult_b(mult_b),
        .div_a(div_a), .div_b(div_b),
        .mult_rst(mult_rst), .div_rst(div_rst),
        .mult_hi(mult_hi), .mult_lo(mult_lo),
        .div_hi(div_hi), .div_lo(div_lo)
    );

    always #5 clock = ~clock;

    int cyc    = 0;
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(string tag, logic [63:0] obs,
                       logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h want=%h",
                      tag, cyc, obs, exp);
    endtask

    function automatic logic [63:0] ref_op(bit s,
            logic [31:0] a, logic [31:0] b);
        longint x, y, q, r;
        logic [63:0] v;
        x = longint'($signed(a));
        y = longint'($signed(b));
        if (!s) begin
            v = 64'(x * y);
        end else if (b == 32'd0) begin
            v = '0;
        end else begin
            q = x / y;
            r = x % y;
            v = {r[31:0], q[31:0]};
        end
        return v;
    endfunction

    // Timeline model: cycle numbers of each event of the current op
    bit          armed = 0;
    int          acc   = -1000;
    int          dcyc  = -1000;
    int          ccyc  = -1000;
    bit          sel_m = 0;
    bit          zero_m = 0;
    bit          dz_m  = 0;
    logic [31:0] ehi = '0, elo = '0;
    logic [31:0] ea = '0, eb = '0;
    logic [63:0] pend = '0;

    always @(posedge clock) begin
        if (cyc == ccyc && reset) {ehi, elo} = pend;
        if (!reset) begin
            armed = 1;
            ehi = '0; elo = '0; dz_m = 0;
            acc = -1000; dcyc = -1000; ccyc = -1000;
        end else if (cyc > dcyc) begin
            if (hilo_we) begin
                if (hilo_sel) ehi = hilo_wdata;
                else          elo = hilo_wdata;
            end
            if (op_req) begin
                acc    = cyc;
                sel_m  = op_sel;
                zero_m = op_sel && (op_b == 32'd0);
                dz_m   = zero_m;
                ea = op_a;
                eb = op_b;
                if (zero_m) begin
                    dcyc = cyc + 1;
                    ccyc = -1000;
                end else begin
                    dcyc = cyc + (op_sel ? DLAT : MLAT) + 2;
                    ccyc = dcyc - 1;
                    pend = ref_op(op_sel, op_a, op_b);
                end
            end
        end
        cyc++;
    end

    // Units present their result only in the cycle it is due
    int          mvc = -1, dvc = -1;
    logic [63:0] mv = '0, dv = '0;
    logic [7:0]  ctrl_o, ctrl_e;
    bit          st;

    always @(negedge clock) begin
        if (armed) begin
            st = (cyc == acc + 1) && !zero_m;
            ctrl_o = {op_ack, busy, done, div_zero,
                      mult_start, div_start, mult_rst, div_rst};
            ctrl_e = {cyc == acc + 1,
                      cyc > acc && cyc <= dcyc,
                      cyc == dcyc, dz_m,
                      st && !sel_m, st && sel_m,
                      !reset, !reset};
            chk("ctrl", 64'(ctrl_o), 64'(ctrl_e));
            chk("hi", 64'(hi), 64'(ehi));
            chk("lo", 64'(lo), 64'(elo));
            if (cyc > acc && cyc < dcyc && !zero_m) begin
                if (sel_m) chk("div_ops", {div_a, div_b}, {ea, eb});
                else chk("mult_ops", {mult_a, mult_b}, {ea, eb});
            end
            if (mult_start) begin
                mv  = ref_op(0, mult_a, mult_b);
                mvc = cyc + MLAT;
            end
            if (div_start) begin
                dv  = ref_op(1, div_a, div_b);
                dvc = cyc + DLAT;
            end
        end
        {mult_hi, mult_lo} = (cyc == mvc) ? mv
                           : {$urandom, $urandom};
        {div_hi, div_lo}   = (cyc == dvc) ? dv
                           : {$urandom, $urandom};
    end

    task automatic step(int k = 1);
        repeat (k) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic mt(bit s, logic [31:0] d);
        hilo_we = 1'b1;
        hilo_sel = s;
        hilo_wdata = d;
        step();
        hilo_we = 1'b0;
    endtask

    task automatic wait_ack();
        int k = 0;
        do begin
            step();
            k++;
        end while (!op_ack && k < 200);
        chk("ack_seen", 64'(op_ack), 64'd1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 200) begin
            step();
            k++;
        end
        chk("idle_seen", 64'(busy), 64'd0);
    endtask

    task automatic req(bit s, logic [31:0] a, logic [31:0] b);
        op_req = 1'b1;
        op_sel = s;
        op_a = a;
        op_b = b;
        wait_ack();
        op_req = 1'b0;
    endtask

    initial begin
        step(3);
        reset = 1'b1;
        step(2);
        mt(0, 32'hDEADBEEF);
        mt(1, 32'h0000CAFE);
        step(2);
        req(0, 32'd7, 32'hFFFFFFFD);
        wait_idle();
        chk("mul_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
        req(1, 32'd100, 32'd7);
        wait_idle();
        chk("div_hilo", {hi, lo}, {32'd2, 32'd14});
        mt(1, 32'h11);
        mt(0, 32'h22);
        req(1, 32'd55, 32'd0);
        wait_idle();
        step(3);
        chk("dz_hold", {32'(div_zero), hi, lo}, {32'd1, 32'h11, 32'h22});
        // second request and MT strobe while the first op is in WAIT
        req(0, 32'd9, 32'd11);
        step(5);
        op_req = 1'b1;
        op_sel = 1'b1;
        op_a = 32'd1000;
        op_b = 32'd9;
        mt(0, 32'd55);
        wait_ack();
        op_req = 1'b0;
        wait_idle();
        chk("held_req", {hi, lo}, {32'd1, 32'd111});
        // MT write in the same cycle as an accepted request
        op_req = 1'b1;
        op_sel = 1'b0;
        op_a = 32'd3;
        op_b = 32'd4;
        hilo_we = 1'b1;
        hilo_sel = 1'b1;
        hilo_wdata = 32'h77;
        wait_ack();
        hilo_we = 1'b0;
        op_req = 1'b0;
        wait_idle();
        req(0, 32'd12345, 32'd678);
        step(10);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("rst_abort", {32'(busy), hi, lo}, 64'd0);
        step(45);
        for (int i = 0; i < 30; i++) begin
            int g;
            g = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1)
                mt(1'($urandom_range(0, 1)), $urandom);
            step(g);
            req(1'($urandom_range(0, 1)), $urandom,
                ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom);
            wait_idle();
        end
        step(3);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencing controller for the multi-cycle multiply and divide units of the multicycle CPU. It accepts one MULT or DIV request at a time from the main control unit and latches the operands. It launches the selected unit with a one-cycle start pulse, waits that unit's fixed latency, then commits the result into the architectural HI/LO registers. It also owns MTHI/MTLO writes, divide-by-zero detection and the busy/stall signal the control unit uses to hold MFHI/MFLO.

## Interface

Parameters:
- MULT_LAT, 33, cycles from the multiplier start-pulse cycle to the first cycle its hi/lo outputs are valid (≥2)
- DIV_LAT, 34, same for the divider (≥2)
- CNT_W, 6, width of the latency down-counter; must hold max(MULT_LAT, DIV_LAT)

Ports:
- clock  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-low; sampled only on the rising edge of clock
- op_req  in  1  request level; held by the requester until op_ack
- op_sel  in  1  0 = MULT, 1 = DIV
- op_a, op_b  in  32  operands (rs, rt)
- hilo_we  in  1  MTHI/MTLO write strobe
- hilo_sel  in  1  0 = LO, 1 = HI
- hilo_wdata  in  32  MTHI/MTLO data
- op_ack  out  1  one-cycle pulse: request accepted
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse: HI/LO committed, or div-by-zero resolved
- div_zero  out  1  last accepted DIV had op_b == 0; sticky until the next acceptance
- hi, lo  out  32  architectural HI/LO
- mult_start, div_start  out  1  unit start pulses
- mult_a, mult_b, div_a, div_b  out  32  unit operands, driven from latched registers
- mult_rst, div_rst  out  1  unit resets, active-high, equal to ~reset (combinational)
- mult_hi, mult_lo  in  32  multiplier product
- div_hi, div_lo  in  32  divider remainder / quotient

## Operation

- Reset (reset = 0 at an edge):
  - State goes to IDLE.
  - hi, lo, operand registers and counter clear to 0.
  - op_ack, busy, done, div_zero and both start signals are 0.
  - Reset overrides every other input.
- States:
  - IDLE: busy = 0.
    - op_req = 1 at an edge: latch op_sel, op_a and op_b; clear div_zero.
    - DIV with op_b == 0: set div_zero and go to FINISH.
    - Otherwise go to LAUNCH.
  - LAUNCH: the start signal of the selected unit is 1; the other unit's start is 0. Load counter with LAT−2. Go to WAIT.
  - WAIT: decrement the counter each cycle. Leave to CAPTURE in the cycle where counter == 0, i.e. after exactly LAT−1 WAIT cycles.
  - CAPTURE: hi/lo ← selected unit's {hi, lo} at the end of the cycle. Go to FINISH.
  - FINISH: done = 1. Go to IDLE.
- op_ack = 1 only in the cycle after acceptance (LAUNCH, or FINISH on div-zero).
- busy = 1 in LAUNCH, WAIT, CAPTURE and FINISH.
- op_req is ignored outside IDLE. A request held through FINISH is accepted in the next IDLE cycle.
- Unit operand outputs hold the latched values from LAUNCH through CAPTURE. Operand outputs of the unselected unit hold their last values.
- Div-by-zero: no unit is started, HI/LO are unchanged, done pulses.
- hilo_we is honoured only in IDLE; it writes the register chosen by hilo_sel. It is dropped in every other state.
  - hilo_we together with an accepted op_req in the same IDLE cycle: the write takes effect, and the later CAPTURE overwrites both HI and LO.
- Signedness is decided by the units; this block only moves 32-bit values and does no arithmetic beyond the op_b == 0 compare.

## Timing

- Request sampled at the edge ending cycle R (IDLE):
  - LAUNCH = R+1
  - WAIT = R+2 … R+LAT
  - CAPTURE = R+LAT+1
  - FINISH = R+LAT+2, with the new hi/lo visible and done = 1
  - IDLE = R+LAT+3
- MULT with default parameters: done at R+35; the next request can be accepted at the edge ending R+36.
- Start pulse is exactly one cycle wide. The unit output is sampled LAT cycles after the start cycle.
- Div-by-zero: op_ack, done and div_zero are all 1 in R+1; IDLE in R+2.
- Reset mid-operation: the operation is abandoned, no done, and hi/lo are 0 in the cycle after the reset edge. Unit resets are asserted for as long as reset = 0.
- Back-to-back requests: minimum spacing is LAT+3 cycles (normal) or 2 cycles (div-by-zero).

## Test plan

- MULT, op_a = 7, op_b = 0xFFFFFFFD (−3), req in cycle R, unit model with LAT 33 → mult_start only in R+1; hi = 0xFFFFFFFF and lo = 0xFFFFFFEB at R+35 with done; busy R+1..R+35.
- DIV, op_a = 100, op_b = 7, DIV_LAT 34 → div_start in R+1; lo = 14 and hi = 2 with done at R+36; div_zero = 0.
- DIV, op_b = 0, with hi = 0x11 and lo = 0x22 preloaded via MTHI/MTLO → op_ack, done and div_zero in R+1; no start; hi/lo unchanged; div_zero stays 1 until the next accepted op.
- Second op_req and hilo_we asserted during WAIT → both ignored; hi/lo reflect only the first op; the held op_req is accepted in the first IDLE cycle after FINISH.
- reset = 0 for 1 cycle during WAIT → next cycle: IDLE, hi = lo = 0, busy = 0, mult_rst = 1 during the reset cycle; no done ever pulses for the aborted op.
- MTLO 0xDEADBEEF in IDLE, then MTHI 0xCAFE → lo = 0xDEADBEEF and hi = 0x0000CAFE, each one cycle after its strobe; no done pulse.
